// File: rtl/cia_keyboard_matrix.sv
// PS/2 keyboard receiver and decoder driving a live C64/C128 8x8 key matrix
// and RESTORE line in front of the CIA1 port inputs.
module cia_keyboard_matrix #(
   parameter int FILTER_LEN     = 8,
   parameter int TIMEOUT_CYCLES = 32000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       ps2_clk,
   input  logic       ps2_dat,
   input  logic [7:0] pa_out,
   input  logic [7:0] pb_out,
   output logic [7:0] pa_in,
   output logic [7:0] pb_in,
   output logic       restore_n,
   output logic [8:0] map_addr,
   output logic       map_req,
   input  logic [7:0] map_data,
   output logic       frame_err
);

   // state     | meaning
   // RX_IDLE   | waiting for a start bit (data low on a clock fall)
   // RX_DATA   | shifting in 8 data bits, LSB first
   // RX_PARITY | sampling the odd-parity bit
   // RX_STOP   | sampling the stop bit, then byte or frame_err
   typedef enum logic [1:0] {RX_IDLE, RX_DATA, RX_PARITY, RX_STOP} rx_state_t;

   localparam int FW = $clog2(FILTER_LEN + 1);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

   logic [1:0]    clk_sync, dat_sync;
   logic          clk_filt, dat_filt, clk_filt_d;
   logic [FW-1:0] clk_cnt, dat_cnt;
   logic          fall;

   rx_state_t     rx_state;
   logic [7:0]    rx_shift, rx_byte;
   logic [2:0]    rx_bits;
   logic          rx_par, byte_valid;
   logic [TW-1:0] rx_tmo;

   logic          ext, rel, resp_pend, buf_vld, busy, dec_vld;
   logic [2:0]    skip;
   logic [7:0]    buf_byte, dec_byte;
   logic [7:0]    key_row [8];
   logic [7:0]    pa_nx, pb_nx;

   always_ff @(posedge clk) begin
      if (reset) begin
         clk_sync   <= 2'b11;
         dat_sync   <= 2'b11;
         clk_filt   <= 1'b1;
         dat_filt   <= 1'b1;
         clk_filt_d <= 1'b1;
         clk_cnt    <= FW'(FILTER_LEN - 1);
         dat_cnt    <= FW'(FILTER_LEN - 1);
      end else begin
         clk_sync   <= {clk_sync[0], ps2_clk};
         dat_sync   <= {dat_sync[0], ps2_dat};
         clk_filt_d <= clk_filt;
         // down-counter: a new level is accepted after FILTER_LEN differing samples
         if (clk_sync[1] == clk_filt) begin
            clk_cnt <= FW'(FILTER_LEN - 1);
         end else if (clk_cnt == '0) begin
            clk_filt <= clk_sync[1];
            clk_cnt  <= FW'(FILTER_LEN - 1);
         end else begin
            clk_cnt <= clk_cnt - 1'b1;
         end
         if (dat_sync[1] == dat_filt) begin
            dat_cnt <= FW'(FILTER_LEN - 1);
         end else if (dat_cnt == '0) begin
            dat_filt <= dat_sync[1];
            dat_cnt  <= FW'(FILTER_LEN - 1);
         end else begin
            dat_cnt <= dat_cnt - 1'b1;
         end
      end
   end

   assign fall = clk_filt_d & ~clk_filt;

   always_ff @(posedge clk) begin
      if (reset) begin
         rx_state   <= RX_IDLE;
         rx_shift   <= '0;
         rx_byte    <= '0;
         rx_bits    <= '0;
         rx_par     <= 1'b0;
         rx_tmo     <= '0;
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
      end else begin
         byte_valid <= 1'b0;
         frame_err  <= 1'b0;
         if (fall)
            rx_tmo <= TW'(TIMEOUT_CYCLES - 1);
         else if (rx_state != RX_IDLE && rx_tmo != '0)
            rx_tmo <= rx_tmo - 1'b1;

         // a stalled partial frame is dropped silently
         if (!fall && rx_state != RX_IDLE && rx_tmo == '0) begin
            rx_state <= RX_IDLE;
         end else if (fall) begin
            unique case (rx_state)
               RX_IDLE: begin
                  if (!dat_filt) begin
                     rx_state <= RX_DATA;
                     rx_bits  <= '0;
                     rx_par   <= 1'b0;
                  end
               end
               RX_DATA: begin
                  rx_shift <= {dat_filt, rx_shift[7:1]};
                  rx_par   <= rx_par ^ dat_filt;
                  rx_bits  <= rx_bits + 1'b1;
                  if (rx_bits == 3'd7)
                     rx_state <= RX_PARITY;
               end
               RX_PARITY: begin
                  rx_par   <= rx_par ^ dat_filt;
                  rx_state <= RX_STOP;
               end
               RX_STOP: begin
                  rx_state <= RX_IDLE;
                  if (rx_par && dat_filt) begin
                     byte_valid <= 1'b1;
                     rx_byte    <= rx_shift;
                  end else begin
                     frame_err  <= 1'b1;
                  end
               end
               default: rx_state <= RX_IDLE;
            endcase
         end
      end
   end

   // a lookup occupies the request cycle and the response cycle
   assign busy     = map_req | resp_pend;
   assign dec_vld  = !busy && (buf_vld || byte_valid);
   assign dec_byte = buf_vld ? buf_byte : rx_byte;

   always_ff @(posedge clk) begin
      if (reset) begin
         ext       <= 1'b0;
         rel       <= 1'b0;
         skip      <= '0;
         buf_vld   <= 1'b0;
         buf_byte  <= '0;
         map_req   <= 1'b0;
         map_addr  <= '0;
         resp_pend <= 1'b0;
         restore_n <= 1'b1;
         for (int i = 0; i < 8; i++) key_row[i] <= '0;
      end else begin
         map_req   <= 1'b0;
         resp_pend <= map_req;

         if (byte_valid && (busy || buf_vld)) begin
            buf_vld  <= 1'b1;
            buf_byte <= rx_byte;
         end else if (dec_vld) begin
            buf_vld  <= 1'b0;
         end

         if (resp_pend) begin
            if (map_data[7]) begin
               if (map_data[6])
                  restore_n <= rel;
               else
                  key_row[map_data[5:3]][map_data[2:0]] <= ~rel;
            end
            ext <= 1'b0;
            rel <= 1'b0;
         end

         if (dec_vld) begin
            if (skip != '0) begin
               skip <= skip - 1'b1;
            end else begin
               unique case (dec_byte)
                  8'hE1: skip <= 3'd7;
                  8'hE0: ext  <= 1'b1;
                  8'hF0: rel  <= 1'b1;
                  8'hAA: begin
                     for (int i = 0; i < 8; i++) key_row[i] <= '0;
                     restore_n <= 1'b1;
                     ext       <= 1'b0;
                     rel       <= 1'b0;
                  end
                  8'hFA, 8'hEE, 8'hFE, 8'h00, 8'hFF: ;
                  default: begin
                     map_addr <= {ext, dec_byte};
                     map_req  <= 1'b1;
                  end
               endcase
            end
         end
      end
   end

   always_comb begin
      pa_nx = pa_out;
      pb_nx = pb_out;
      for (int i = 0; i < 8; i++) begin
         for (int j = 0; j < 8; j++) begin
            if (key_row[i][j] && !pb_out[j]) pa_nx[i] = 1'b0;
            if (key_row[i][j] && !pa_out[i]) pb_nx[j] = 1'b0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pa_in <= 8'hFF;
         pb_in <= 8'hFF;
      end else begin
         pa_in <= pa_nx;
         pb_in <= pb_nx;
      end
   end

endmodule

// File: tb/tb_cia_keyboard_matrix.sv
// Directed bench for cia_keyboard_matrix: PS/2 frames in, keymap ROM model,
// matrix read-back table and multi-cycle corner sequences.
module tb_cia_keyboard_matrix;

   localparam int TIMEOUT = 32000;

   logic       clk = 1'b0;
   logic       reset;
   logic       ps2_clk, ps2_dat;
   logic [7:0] pa_out, pb_out, pa_in, pb_in, map_data;
   logic       restore_n, map_req, frame_err;
   logic [8:0] map_addr;
   logic [7:0] rom_val;

   int checks = 0;
   int errors = 0;
   int req_cnt = 0;
   int req_wide = 0;
   int err_cnt = 0;
   logic       req_prev = 1'b0;
   logic [8:0] last_addr = '0;

   typedef struct {
      logic [7:0] pa_o;
      logic [7:0] pb_o;
      logic [7:0] exp_pa;
      logic [7:0] exp_pb;
   } rb_vec_t;
   rb_vec_t tbl [5];

   cia_keyboard_matrix #(.FILTER_LEN(8), .TIMEOUT_CYCLES(TIMEOUT)) dut (
      .clk(clk), .reset(reset), .ps2_clk(ps2_clk), .ps2_dat(ps2_dat),
      .pa_out(pa_out), .pb_out(pb_out), .pa_in(pa_in), .pb_in(pb_in),
      .restore_n(restore_n), .map_addr(map_addr), .map_req(map_req),
      .map_data(map_data), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   // registered keymap ROM: answer is visible the cycle after map_req
   always @(posedge clk) map_data <= map_req ? rom_val : 8'h00;

   always @(negedge clk) begin
      if (map_req) begin
         req_cnt++;
         last_addr = map_addr;
         if (req_prev) req_wide++;
      end
      req_prev = map_req;
      if (frame_err) err_cnt++;
   end

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   task automatic ps2_bit(input logic b);
      ps2_dat = b;
      repeat (15) @(posedge clk);
      ps2_clk = 1'b0;
      repeat (15) @(posedge clk);
      ps2_clk = 1'b1;
   endtask

   task automatic send_frame(input logic [7:0] d, input logic par_flip, input logic stop_bit);
      ps2_bit(1'b0);
      for (int i = 0; i < 8; i++) ps2_bit(d[i]);
      ps2_bit(~^d ^ par_flip);
      ps2_bit(stop_bit);
      ps2_dat = 1'b1;
      repeat (40) @(posedge clk);
   endtask

   task automatic send(input logic [7:0] d);
      send_frame(d, 1'b0, 1'b1);
   endtask

   task automatic set_ports(input logic [7:0] a, input logic [7:0] b);
      pa_out = a;
      pb_out = b;
      repeat (2) @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      int r0, e0;
      tbl[0] = '{8'hFD, 8'hFF, 8'hFD, 8'hFB};
      tbl[1] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF};
      tbl[2] = '{8'hFF, 8'hFB, 8'hFD, 8'hFB};
      tbl[3] = '{8'h00, 8'hFF, 8'h00, 8'hFB};
      tbl[4] = '{8'hFE, 8'hFF, 8'hFE, 8'hFF};

      reset = 1'b1; ps2_clk = 1'b1; ps2_dat = 1'b1;
      pa_out = 8'hFF; pb_out = 8'hFF; rom_val = 8'h00;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("reset_pa_in", {8'h0, pa_in}, 16'h00FF);
      check("reset_pb_in", {8'h0, pb_in}, 16'h00FF);
      check("reset_restore_n", {15'h0, restore_n}, 16'h0001);
      check("reset_map_addr", {7'h0, map_addr}, 16'h0000);
      check("reset_map_req", {15'h0, map_req}, 16'h0000);
      check("reset_frame_err", {15'h0, frame_err}, 16'h0000);
      reset = 1'b0;
      repeat (20) @(posedge clk);

      // press (pa 1, pb 2)
      rom_val = 8'h8A;
      send(8'h1C);
      check("press_req_count", 16'(req_cnt), 16'd1);
      check("press_map_addr", {7'h0, last_addr}, 16'h001C);
      for (int k = 0; k < 5; k++) begin
         set_ports(tbl[k].pa_o, tbl[k].pb_o);
         check($sformatf("readback_pa_%0d", k), {8'h0, pa_in}, {8'h0, tbl[k].exp_pa});
         check($sformatf("readback_pb_%0d", k), {8'h0, pb_in}, {8'h0, tbl[k].exp_pb});
      end

      // release, then release again
      send(8'hF0); send(8'h1C);
      set_ports(8'h00, 8'hFF);
      check("release_pb_in", {8'h0, pb_in}, 16'h00FF);
      check("release_req_count", 16'(req_cnt), 16'd2);
      send(8'hF0); send(8'h1C);
      set_ports(8'h00, 8'hFF);
      check("release_again_pb_in", {8'h0, pb_in}, 16'h00FF);
      check("release_again_pa_in", {8'h0, pa_in}, 16'h0000);

      // extended prefix with an invalid ROM entry
      rom_val = 8'h00;
      send(8'hE0); send(8'h75);
      check("ext_map_addr", {7'h0, last_addr}, 16'h0175);
      send(8'h75);
      check("ext_cleared_addr", {7'h0, last_addr}, 16'h0075);
      set_ports(8'h00, 8'hFF);
      check("invalid_no_change", {8'h0, pb_in}, 16'h00FF);

      // parity and stop errors
      rom_val = 8'h8A;
      r0 = req_cnt; e0 = err_cnt;
      send_frame(8'h1C, 1'b1, 1'b1);
      check("parity_err_count", 16'(err_cnt - e0), 16'd1);
      check("parity_no_req", 16'(req_cnt - r0), 16'd0);
      send_frame(8'h1C, 1'b0, 1'b0);
      check("stop_err_count", 16'(err_cnt - e0), 16'd2);
      check("stop_no_req", 16'(req_cnt - r0), 16'd0);
      send(8'h1C);
      check("after_err_req", 16'(req_cnt - r0), 16'd1);
      set_ports(8'h00, 8'hFF);
      check("after_err_pressed", {8'h0, pb_in}, 16'h00FB);

      // truncated frame followed by a long idle
      e0 = err_cnt; r0 = req_cnt;
      ps2_bit(1'b0);
      ps2_bit(1'b1); ps2_bit(1'b0); ps2_bit(1'b1); ps2_bit(1'b1); ps2_bit(1'b0);
      ps2_dat = 1'b1;
      repeat (TIMEOUT + 200) @(posedge clk);
      check("timeout_no_err", 16'(err_cnt - e0), 16'd0);
      send(8'hF0); send(8'h1C);
      check("timeout_then_req", 16'(req_cnt - r0), 16'd1);
      check("timeout_then_addr", {7'h0, last_addr}, 16'h001C);
      check("timeout_frame_ok", 16'(err_cnt - e0), 16'd0);
      set_ports(8'h00, 8'hFF);
      check("timeout_released", {8'h0, pb_in}, 16'h00FF);

      // key (0,0) plus RESTORE, then keyboard self-test reset byte
      rom_val = 8'h80;
      send(8'h16);
      set_ports(8'hFE, 8'hFF);
      check("key00_pb_in", {8'h0, pb_in}, 16'h00FE);
      rom_val = 8'hC0;
      send(8'h07);
      check("restore_held", {15'h0, restore_n}, 16'h0000);
      send(8'hAA);
      check("aa_restore_n", {15'h0, restore_n}, 16'h0001);
      set_ports(8'h00, 8'hFF);
      check("aa_pb_in", {8'h0, pb_in}, 16'h00FF);

      // pause sequence: E1 then seven skipped bytes
      rom_val = 8'h8A;
      r0 = req_cnt;
      send(8'hE1);
      send(8'h14); send(8'h77); send(8'hE1); send(8'hF0);
      send(8'h14); send(8'hF0); send(8'h77);
      check("pause_no_req", 16'(req_cnt - r0), 16'd0);
      send(8'h1C);
      check("after_pause_req", 16'(req_cnt - r0), 16'd1);
      set_ports(8'hFD, 8'hFF);
      check("after_pause_press", {8'h0, pb_in}, 16'h00FB);

      check("map_req_one_cycle", 16'(req_wide), 16'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cia_keyboard_matrix.md
Name: cia_keyboard_matrix

Overview:
- Converts a PS/2 keyboard stream into a live 8x8 C64/C128 key matrix and restore line.
- Sits directly upstream of CIA1 port inputs: consumes the CIA's pa_out/pb_out drive and produces pa_in/pb_in.
- Scancode-to-matrix translation is an external registered ROM reached over a request/response lookup port.

Parameters:
FILTER_LEN, 8, consecutive identical samples required to accept a new ps2_clk/ps2_dat level.
TIMEOUT_CYCLES, 32000, clk cycles without a ps2_clk falling edge before a partial frame is discarded.

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_dat  in  1  raw PS/2 data, asynchronous
pa_out  in  8  CIA port A drive, 1 = released
pb_out  in  8  CIA port B drive, 1 = released
pa_in  out  8  port A read-back to CIA
pb_in  out  8  port B read-back to CIA
restore_n  out  1  RESTORE key, low while held
map_addr  out  9  {extended, scancode} sent to keymap ROM
map_req  out  1  one-cycle lookup strobe
map_data  in  8  {valid, restore, pa_idx[2:0], pb_idx[2:0]}, valid the cycle after map_req
frame_err  out  1  one-cycle pulse on parity/stop error

Behaviour:
- Reset: pa_in=FF, pb_in=FF, restore_n=1, map_addr=0, map_req=0, frame_err=0. Matrix, prefix flags, skip counter and receiver all cleared; receiver returns to IDLE.
- Input conditioning: 2-FF synchroniser on ps2_clk and ps2_dat, then a FILTER_LEN stability filter. Filtered clock 1->0 = sample edge.
- Receiver FSM:
  - IDLE: on edge, data=0 -> DATA with bit count 0. Data=1 -> stay IDLE, no error.
  - DATA: 8 edges, LSB first.
  - PARITY: one edge; odd parity over data+parity required.
  - STOP: one edge; data must be 1. Then back to IDLE.
  - Good frame: 1-cycle byte_valid pulse to the decoder.
  - Parity or stop failure: frame_err pulses once, byte discarded.
- Timeout: in any state except IDLE, a cycle counter reloads on each edge. Reaching TIMEOUT_CYCLES -> IDLE silently, no frame_err.
- Decoder, per accepted byte:
  - Skip counter nonzero: decrement, byte ignored.
  - E1: skip counter=7 (pause sequence).
  - E0: set ext flag.
  - F0: set rel flag.
  - AA: clear whole matrix, restore_n=1, clear flags.
  - FA, EE, FE, 00, FF: ignored, flags untouched.
  - Any other byte: map_addr={ext,byte}, map_req=1 for exactly 1 cycle.
- Lookup response, sampled the cycle after map_req:
  - valid=1 and restore=0: key[pa_idx][pb_idx] <= ~rel.
  - valid=1 and restore=1: restore_n <= rel.
  - valid=0: no change.
  - ext and rel cleared in the same cycle regardless of valid.
- A byte arriving during the lookup cycle is held in a 1-entry buffer and processed next cycle; no loss.
- Matrix read-back, registered, 1-cycle latency from pa_out/pb_out/matrix change:
  - pa_in[i] = pa_out[i] AND, over all j, NOT(key[i][j] AND NOT pb_out[j]).
  - pb_in[j] = pb_out[j] AND, over all i, NOT(key[i][j] AND NOT pa_out[i]).
  - Multiple pressed keys give natural ghosting; no suppression.
- Press of an already-pressed key and release of an unpressed key are idempotent.
- Reset mid-frame or mid-lookup: everything returns to reset values next cycle; a pending map_data is ignored.

Test Plan:
- Frame 0x1C (parity 0, stop 1); ROM returns 0x8A (pa 1, pb 2). Drive pa_out=FD -> map_addr=0x01C, one map_req, pb_in=FB one cycle later; pa_out=FF -> pb_in=FF.
- With key held, send F0,1C -> key cleared, pb_in=FF with pa_out=00; second F0,1C changes nothing.
- Send E0,75 -> map_addr=0x175. ROM returns 0x00 -> matrix unchanged and ext flag cleared: following 75 gives map_addr=0x075.
- Frame 0x1C with parity bit 1 -> frame_err one cycle, no map_req. Then a valid 0x1C decodes normally.
- Stop after 5 data bits and idle TIMEOUT_CYCLES -> receiver back in IDLE, no frame_err; next full frame decodes correctly.
- Press key (pa 0, pb 0) plus restore (ROM 0xC0), then send AA -> matrix all released, restore_n=1, pb_in=FF for pa_out=00. Separately, E1 plus 7 bytes -> no map_req.
